ps2_key_decoder: RTL and testbench

//  Producer of the 11-bit ps2_key event word {toggle, pressed, extended, code[7:0]} that the core's keyboard handler consumes.
//  It deserialises raw PS/2 device clock/data and strips the E0 (extended) and F0 (break) prefixes.

---
 rtl/ps2_key_decoder.sv | 194 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Deserialises a raw PS/2 keyboard clock/data pair in the clk_sys
//            domain and turns scan-code bytes into toggle-flagged key events
//            {toggle, pressed, extended, code[7:0]}, stripping E0/F0 prefixes.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 36000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int unsigned c_wd_w      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  c_fcnt_last = 8'(FILTER_LEN - 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic              r_clk_s1, r_clk_s2;
  logic              r_dat_s1, r_dat_s2;
  logic              r_filt, r_filt_d;
  logic [7:0]        r_fcnt;
  logic [c_wd_w-1:0] r_wd;
  state_t            r_state, w_state_nx;
  logic [2:0]        r_cnt, w_cnt_nx;
  logic [7:0]        r_sreg, w_sreg_nx;
  logic              r_par, w_par_nx;
  logic              r_ext, r_brk;
  logic              w_fe;
  logic              w_eval;
  logic              w_good;
  logic              w_timeout;

  // Two-flop synchronisers; idle PS/2 lines sit high, so reset to 1.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock deglitch: level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == c_fcnt_last) begin
        r_filt <= ~r_filt;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

  assign w_fe = r_filt_d & ~r_filt;

  // Watchdog: measures the gap between falling edges while a frame is open.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wd <= '0;
    end else if (w_fe || (r_state == ST_IDLE) || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Frame FSM state and shift registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sreg  <= w_sreg_nx;
      r_par   <= w_par_nx;
    end
  end

  // Next-state logic; w_eval marks the stop-bit edge where the frame is judged.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sreg_nx  = r_sreg;
    w_par_nx   = r_par;
    w_eval     = 1'b0;
    w_timeout  = 1'b0;
    w_good     = r_dat_s2 & (^{r_sreg, r_par});
    if ((r_state != ST_IDLE) && !w_fe && (r_wd == c_wd_last)) begin
      w_timeout  = 1'b1;
      w_state_nx = ST_IDLE;
    end else if (w_fe) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nx = ST_DATA;
            w_cnt_nx   = '0;
          end
        end
        ST_DATA: begin
          w_sreg_nx = {r_dat_s2, r_sreg[7:1]};
          w_cnt_nx  = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_state_nx = ST_PARITY;
          end
        end
        ST_PARITY: begin
          w_par_nx   = r_dat_s2;
          w_state_nx = ST_STOP;
        end
        ST_STOP: begin
          w_eval     = 1'b1;
          w_state_nx = ST_IDLE;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Byte decode: prefix tracking, event generation and status pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (w_timeout) begin
        frame_err <= 1'b1;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
      end else if (w_eval) begin
        if (w_good) begin
          byte_valid <= 1'b1;
          byte_data  <= r_sreg;
          case (r_sreg)
            8'hE0: r_ext <= 1'b1;
            8'hF0: r_brk <= 1'b1;
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
            default: begin
              ps2_key <= {~ps2_key[10], ~r_brk, r_ext, r_sreg};
              r_ext   <= 1'b0;
              r_brk   <= 1'b0;
            end
          endcase
        end else begin
          frame_err <= 1'b1;
          r_ext     <= 1'b0;
          r_brk     <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Scoreboard bench for ps2_key_decoder. Stimulus pushes expected
//            events computed by a keyboard-protocol model; a monitor pops and
//            compares whenever the decoder reports a byte or a frame error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int FILT = 4;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_err   (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    logic [10:0] key;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Keyboard-level model state
  bit          m_ext, m_brk;
  logic [10:0] m_key;
  logic [7:0]  m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_key = '0; m_last = '0;
  endtask

  task automatic model_good(input logic [7:0] b);
    exp_t e;
    m_last = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_ext = 0; m_brk = 0;
    end
    e.is_err = 0; e.data = m_last; e.key = m_key;
    q.push_back(e);
  endtask

  task automatic model_bad();
    exp_t e;
    m_ext = 0; m_brk = 0;
    e.is_err = 1; e.data = m_last; e.key = m_key;
    q.push_back(e);
  endtask

  // Monitor: every reported event must match the oldest expectation.
  always @(negedge clk_sys) begin
    if (!reset && (byte_valid || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: byte_valid=%0b frame_err=%0b key=%0h, expected no output",
                 byte_valid, frame_err, ps2_key);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("byte_valid", 32'(byte_valid), 32'(!e.is_err));
        check("frame_err", 32'(frame_err), 32'(e.is_err));
        check("byte_data", 32'(byte_data), 32'(e.data));
        check("ps2_key", 32'(ps2_key), 32'(e.key));
      end
    end
  end

  // Drive n bits LSB first, one PS/2 clock low pulse of low_cyc cycles per bit.
  task automatic send_bits(input logic [10:0] bits, input int n, input int low_cyc);
    for (int i = 0; i < n; i++) begin
      ps2_data_in = bits[i];
      repeat (HALF) @(posedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (low_cyc) @(posedge clk_sys);
      ps2_clk_in = 1'b1;
    end
    repeat (HALF) @(posedge clk_sys);
    ps2_data_in = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit perr, input bit serr, input int low_cyc);
    logic par;
    par = (~^b) ^ perr;
    if (perr || serr) model_bad();
    else model_good(b);
    send_bits({~serr, par, b, 1'b0}, 11, low_cyc);
    repeat (10) @(posedge clk_sys);
  endtask

  task automatic check_outputs_zero(input string name);
    @(negedge clk_sys);
    check({name, "_key"}, 32'(ps2_key), 32'h0);
    check({name, "_valid"}, 32'(byte_valid), 32'h0);
    check({name, "_data"}, 32'(byte_data), 32'h0);
    check({name, "_err"}, 32'(frame_err), 32'h0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    model_reset();
    repeat (5) @(posedge clk_sys);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);

    // Plain make, then extended break
    send_byte(8'h29, 0, 0, HALF);
    check("t1_key", 32'(ps2_key), 32'h629);
    send_byte(8'hE0, 0, 0, HALF);
    send_byte(8'hF0, 0, 0, HALF);
    send_byte(8'h75, 0, 0, HALF);
    check("t2_key", 32'(ps2_key), 32'h175);

    // Parity error, then bad stop clearing a pending break
    send_byte(8'h1C, 1, 0, HALF);
    send_byte(8'hF0, 0, 1, HALF);
    send_byte(8'h1C, 0, 0, HALF);

    // Prefixes in reverse order and repeated
    send_byte(8'hF0, 0, 0, HALF);
    send_byte(8'hE0, 0, 0, HALF);
    send_byte(8'hE0, 0, 0, HALF);
    send_byte(8'h6B, 0, 0, HALF);

    // Partial frame then silence: watchdog must abandon it
    model_bad();
    send_bits({2'b11, 8'h5A, 1'b0}, 5, HALF);
    n = 0;
    while (!frame_err && n < TMO + 10) begin
      @(negedge clk_sys);
      n++;
    end
    check("timeout_in_window", 32'((n >= TMO - 2*HALF) && (n <= TMO - 2*HALF + FILT + 10)), 32'h1);
    repeat (20) @(posedge clk_sys);
    send_byte(8'h16, 0, 0, HALF);

    // Short low glitch with data low must not start a frame
    ps2_data_in = 1'b0;
    @(posedge clk_sys);
    ps2_clk_in = 1'b0;
    repeat (FILT - 1) @(posedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (HALF) @(posedge clk_sys);
    ps2_data_in = 1'b1;
    repeat (HALF) @(posedge clk_sys);
    send_byte(8'h24, 0, 0, HALF);
    // Narrow but acceptable clock low pulses
    send_byte(8'h3A, 0, 0, FILT + 2);

    // Reset in the middle of a frame
    send_bits({2'b11, 8'h1C, 1'b0}, 5, HALF);
    reset = 1'b1;
    model_reset();
    check_outputs_zero("midreset");
    repeat (5) @(posedge clk_sys);
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);
    send_byte(8'h1C, 0, 0, HALF);
    check("t6_key", 32'(ps2_key), 32'h61C);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int r;
      bit pe, se;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: begin
          logic [7:0] sp[6];
          sp = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
          b = sp[$urandom_range(0, 5)];
        end
        default: b = 8'($urandom);
      endcase
      pe = ($urandom_range(0, 7) == 0);
      se = !pe && ($urandom_range(0, 9) == 0);
      send_byte(b, pe, se, ($urandom_range(0, 1) == 0) ? HALF : FILT + 2);
    end

    repeat (50) @(posedge clk_sys);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
